// File: rtl/sd_trace_parser.sv
// ASCII memory-trace line parser: "<op> <hex addr>\n" -> {write, addr} records,
// buffered in a first-word-fall-through FIFO with saturating line/error/drop statistics.
module sd_trace_parser #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_en,
  input  logic [7:0]                  in_byte,
  input  logic                        in_flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_write,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            line_cnt,
  output logic [CNT_W-1:0]            err_cnt,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic                        overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
  } rec_t;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_SEP  = 3'd1,
    S_ADDR = 3'd2,
    S_TAIL = 3'd3,
    S_SKIP = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic [3:0]        ndig_q, ndig_d;
  logic              flush_pend_q, flush_pend_d;
  logic              push_q, push_d;
  rec_t              rec_q, rec_d;
  rec_t              mem_q [FIFO_DEPTH];
  rec_t              mem_d [FIFO_DEPTH];
  logic [LVL_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  line_q, line_d, err_q, err_d, drop_q, drop_d;
  logic              ovf_q, ovf_d;

  logic       ev, eol, ws, cr, opch, opw, xch, hexv;
  logic [3:0] nib;
  logic       err_inc;
  logic [LVL_W-1:0] level;
  logic       full, do_pop, do_push, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Byte classification; a flush that coincides with a byte is deferred one cycle
  always_comb begin
    ev           = 1'b0;
    eol          = 1'b0;
    ws           = 1'b0;
    cr           = 1'b0;
    opch         = 1'b0;
    opw          = 1'b0;
    xch          = 1'b0;
    hexv         = 1'b0;
    nib          = 4'd0;
    flush_pend_d = 1'b0;
    if (in_en) begin
      ev           = 1'b1;
      eol          = (in_byte == 8'h0A);
      cr           = (in_byte == 8'h0D);
      ws           = (in_byte == 8'h20) || (in_byte == 8'h09);
      opch         = (in_byte == 8'h52) || (in_byte == 8'h72) ||
                     (in_byte == 8'h57) || (in_byte == 8'h77);
      opw          = (in_byte == 8'h57) || (in_byte == 8'h77);
      xch          = (in_byte == 8'h78) || (in_byte == 8'h58);
      flush_pend_d = flush_pend_q | in_flush;
      if (in_byte inside {[8'h30:8'h39]}) begin
        hexv = 1'b1;
        nib  = in_byte[3:0];
      end else if ((in_byte inside {[8'h41:8'h46]}) || (in_byte inside {[8'h61:8'h66]})) begin
        hexv = 1'b1;
        nib  = 4'(in_byte[3:0] + 4'd9);
      end
    end else begin
      ev  = flush_pend_q | in_flush;
      eol = ev;
    end
  end

  // Line parser next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    push_d  = 1'b0;
    rec_d   = rec_q;
    err_inc = 1'b0;
    if (ev && !cr) begin
      unique case (state_q)
        S_OP: begin
          if (opch) begin
            op_d    = opw;
            state_d = S_SEP;
          end else if (!ws && !eol) begin
            state_d = S_SKIP;
          end
        end
        S_SEP: begin
          if (ws) begin
            state_d = S_ADDR;
            ndig_d  = 4'd0;
            acc_d   = '0;
          end else if (eol) begin
            err_inc = 1'b1;
            state_d = S_OP;
          end else begin
            state_d = S_SKIP;
          end
        end
        S_ADDR: begin
          if (eol) begin
            if (ndig_q != 4'd0) begin
              push_d     = 1'b1;
              rec_d.write = op_q;
              rec_d.addr  = acc_q;
            end else begin
              err_inc = 1'b1;
            end
            state_d = S_OP;
          end else if (ws) begin
            if (ndig_q != 4'd0) state_d = S_TAIL;
          end else if (hexv) begin
            acc_d  = {acc_q[ADDR_W-5:0], nib};
            ndig_d = (ndig_q == 4'd15) ? 4'd15 : ndig_q + 4'd1;
          end else if (xch && (ndig_q == 4'd1) && (acc_q == '0)) begin
            ndig_d = 4'd0;
          end else begin
            state_d = S_SKIP;
          end
        end
        S_TAIL: begin
          if (eol) begin
            push_d      = 1'b1;
            rec_d.write = op_q;
            rec_d.addr  = acc_q;
            state_d     = S_OP;
          end else if (!ws) begin
            state_d = S_SKIP;
          end
        end
        S_SKIP: begin
          if (eol) begin
            err_inc = 1'b1;
            state_d = S_OP;
          end
        end
        default: state_d = S_OP;
      endcase
    end
  end

  // FIFO and statistics; a push into a full FIFO succeeds only alongside a pop
  always_comb begin
    level   = wr_q - rd_q;
    full    = (level == LVL_W'(FIFO_DEPTH));
    do_pop  = (level != '0) && out_ready;
    do_push = push_q && (!full || do_pop);
    drop    = push_q && full && !do_pop;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q[PTR_W-1:0]] = rec_q;
    wr_d    = wr_q + LVL_W'(do_push);
    rd_d    = rd_q + LVL_W'(do_pop);
    line_d  = sat_inc(line_q, do_push);
    err_d   = sat_inc(err_q, err_inc);
    drop_d  = sat_inc(drop_q, drop);
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_OP;
      op_q         <= 1'b0;
      acc_q        <= '0;
      ndig_q       <= 4'd0;
      flush_pend_q <= 1'b0;
      push_q       <= 1'b0;
      rec_q        <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      line_q       <= '0;
      err_q        <= '0;
      drop_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      ndig_q       <= ndig_d;
      flush_pend_q <= flush_pend_d;
      push_q       <= push_d;
      rec_q        <= rec_d;
      mem_q        <= mem_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      line_q       <= line_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_valid  = (level != '0);
  assign out_write  = mem_q[rd_q[PTR_W-1:0]].write;
  assign out_addr   = mem_q[rd_q[PTR_W-1:0]].addr;
  assign fifo_level = level;
  assign line_cnt   = line_q;
  assign err_cnt    = err_q;
  assign drop_cnt   = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sd_trace_parser.sv
// Directed bench for sd_trace_parser: parsing, error lines, flush, mid-line reset,
// FIFO overflow and full-FIFO push with simultaneous pop.
module tb_sd_trace_parser;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_en;
  logic [7:0]  in_byte;
  logic        in_flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_write;
  logic [31:0] out_addr;
  logic [4:0]  fifo_level;
  logic [15:0] line_cnt;
  logic [15:0] err_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  sd_trace_parser #(.ADDR_W(32), .FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_en      (in_en),
    .in_byte    (in_byte),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_write  (out_write),
    .out_addr   (out_addr),
    .fifo_level (fifo_level),
    .line_cnt   (line_cnt),
    .err_cnt    (err_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_en   = 1'b1;
    in_byte = b;
    tick();
    in_en   = 1'b0;
    in_byte = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pop_chk(input string tag, input logic w, input logic [31:0] a);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_write"}, 64'(out_write), 64'(w));
    chk({tag, "_addr"},  64'(out_addr),  64'(a));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rstn      = 1'b0;
    in_en     = 1'b0;
    in_byte   = 8'h00;
    in_flush  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(out_valid),  64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_line",  64'(line_cnt),   64'd0);
    chk("rst_err",   64'(err_cnt),    64'd0);
    chk("rst_drop",  64'(drop_cnt),   64'd0);
    chk("rst_ovf",   64'(overflow),   64'd0);
    rstn = 1'b1;
    tick();

    // Basic read record with 0x prefix
    send_str("R 0x1A2B\n");
    tick();
    chk("r1_level", 64'(fifo_level), 64'd1);
    chk("r1_line",  64'(line_cnt),   64'd1);
    pop_chk("r1", 1'b0, 32'h0000_1A2B);
    chk("r1_empty", 64'(out_valid),  64'd0);

    // Tab separator, trailing space, CR, and >8 digits truncation
    send_str("w\t00ff \r\n");
    send_str("W 123456789\n");
    tick();
    chk("w2_level", 64'(fifo_level), 64'd2);
    pop_chk("w2a", 1'b1, 32'h0000_00FF);
    pop_chk("w2b", 1'b1, 32'h2345_6789);
    chk("w2_line",  64'(line_cnt),   64'd3);

    // Malformed lines and blank lines
    send_str("X 10\n");
    send_str("R \n");
    send_str("R 1g\n");
    send_str("\n\n");
    tick();
    chk("err_cnt",   64'(err_cnt),    64'd3);
    chk("err_line",  64'(line_cnt),   64'd3);
    chk("err_level", 64'(fifo_level), 64'd0);

    // Flush terminates an unterminated last line
    send_str("R 40");
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    tick();
    chk("fl_level", 64'(fifo_level), 64'd1);
    pop_chk("fl", 1'b0, 32'h0000_0040);

    // Flush coincident with the final byte: byte first, then EOL
    send_str("R 4");
    in_en    = 1'b1;
    in_byte  = 8'h31;
    in_flush = 1'b1;
    tick();
    in_en    = 1'b0;
    in_flush = 1'b0;
    tick();
    tick();
    chk("fl2_level", 64'(fifo_level), 64'd1);
    pop_chk("fl2", 1'b0, 32'h0000_0041);
    chk("fl2_line",  64'(line_cnt),   64'd5);

    // Reset mid-line discards the partial line and returns to S_OP
    send_str("W 12");
    rstn = 1'b0;
    tick();
    chk("mr_line", 64'(line_cnt), 64'd0);
    rstn = 1'b1;
    tick();
    send_str("\n");
    tick();
    chk("mr_level", 64'(fifo_level), 64'd0);
    chk("mr_err",   64'(err_cnt),    64'd0);
    send_str("R 5\n");
    tick();
    chk("mr_line2", 64'(line_cnt), 64'd1);
    pop_chk("mr", 1'b0, 32'h0000_0005);

    // Overflow: 17 lines into a 16-deep FIFO with no consumer
    for (int i = 1; i <= 17; i++) send_str($sformatf("R %0h\n", i));
    tick();
    chk("of_level", 64'(fifo_level), 64'd16);
    chk("of_drop",  64'(drop_cnt),   64'd1);
    chk("of_ovf",   64'(overflow),   64'd1);
    chk("of_line",  64'(line_cnt),   64'd17);

    // Full FIFO, pop in the same cycle as the push
    send_str("W abc\n");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fp_level", 64'(fifo_level), 64'd16);
    chk("fp_drop",  64'(drop_cnt),   64'd1);
    chk("fp_line",  64'(line_cnt),   64'd18);

    for (int i = 2; i <= 16; i++) pop_chk($sformatf("drain%0d", i), 1'b0, 32'(i));
    pop_chk("drain_abc", 1'b1, 32'h0000_0ABC);
    chk("dr_level", 64'(fifo_level), 64'd0);
    chk("dr_valid", 64'(out_valid),  64'd0);
    chk("dr_ovf",   64'(overflow),   64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
